// File: rtl/uart_cmd_responder_pkg.sv
// Shared command/response codes and FSM state encoding for the UART command responder.
package uart_cmd_responder_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam int unsigned ST_W = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_GET_DATA = 3'd2;
    localparam logic [2:0] ST_GET_CSUM = 3'd3;
    localparam logic [2:0] ST_EXEC     = 3'd4;
    localparam logic [2:0] ST_RD_WAIT  = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;

endpackage

// File: rtl/uart_cmd_responder_timer.sv
// Saturating inter-byte timer; expire pulses once for one cycle when the count reaches TIMEOUT.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT = 16000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // Counter stops at CNT_MAX, so expire fires once and never again until cleared
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (enable && (cnt != CNT_MAX)) begin
            cnt    <= cnt + CNT_W'(1);
            expire <= (cnt == (CNT_MAX - CNT_W'(1)));
        end else begin
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-level command responder: decodes W/R packets into register strobes and sends one response byte.
// Optional trailing XOR checksum byte enabled by defining CMD_CHECKSUM_EN.
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16000,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_rcv,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic              proto_err
);

    logic [ST_W-1:0]   state, state_nxt;
    logic              cmd_wr, cmd_wr_nxt;
    logic [7:0]        resp_q, resp_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        wdata_nxt;
    logic              wr_nxt, rd_nxt, start_nxt, err_nxt;
    logic [7:0]        txd_nxt;
    logic              tmr_en, tmr_expire;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]        csum_q, csum_nxt;
`endif

`ifdef CMD_CHECKSUM_EN
    assign tmr_en = (state == ST_GET_ADDR) || (state == ST_GET_DATA) || (state == ST_GET_CSUM);
`else
    assign tmr_en = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
`endif

    cmd_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (rx_rcv || !tmr_en),
        .enable (tmr_en),
        .expire (tmr_expire)
    );

    // Strobes and tx_start are issued on the transition edge so they coincide with EXEC / first RESP cycle
    always_comb begin
        state_nxt  = state;
        cmd_wr_nxt = cmd_wr;
        resp_nxt   = resp_q;
        addr_nxt   = reg_addr;
        wdata_nxt  = reg_wdata;
        wr_nxt     = 1'b0;
        rd_nxt     = 1'b0;
        start_nxt  = 1'b0;
        txd_nxt    = tx_data;
        err_nxt    = 1'b0;
`ifdef CMD_CHECKSUM_EN
        csum_nxt   = csum_q;
`endif
        case (state)
            ST_IDLE: begin
                if (rx_rcv) begin
`ifdef CMD_CHECKSUM_EN
                    csum_nxt = rx_data;
`endif
                    if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                        cmd_wr_nxt = (rx_data == CMD_WR);
                        state_nxt  = ST_GET_ADDR;
                    end else begin
                        resp_nxt  = RSP_NAK;
                        err_nxt   = 1'b1;
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_rcv) begin
                    addr_nxt = rx_data[ADDR_W-1:0];
`ifdef CMD_CHECKSUM_EN
                    csum_nxt = csum_q ^ rx_data;
`endif
                    if (cmd_wr) begin
                        state_nxt = ST_GET_DATA;
                    end else begin
`ifdef CMD_CHECKSUM_EN
                        state_nxt = ST_GET_CSUM;
`else
                        rd_nxt    = 1'b1;
                        state_nxt = ST_EXEC;
`endif
                    end
                end else if (tmr_expire) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rx_rcv) begin
                    wdata_nxt = rx_data;
`ifdef CMD_CHECKSUM_EN
                    csum_nxt  = csum_q ^ rx_data;
                    state_nxt = ST_GET_CSUM;
`else
                    wr_nxt    = 1'b1;
                    state_nxt = ST_EXEC;
`endif
                end else if (tmr_expire) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`ifdef CMD_CHECKSUM_EN
            ST_GET_CSUM: begin
                if (rx_rcv) begin
                    if (rx_data == csum_q) begin
                        wr_nxt    = cmd_wr;
                        rd_nxt    = !cmd_wr;
                        state_nxt = ST_EXEC;
                    end else begin
                        resp_nxt  = RSP_NAK;
                        err_nxt   = 1'b1;
                        state_nxt = ST_RESP;
                    end
                end else if (tmr_expire) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`endif
            ST_EXEC: begin
                err_nxt = rx_rcv;
                if (cmd_wr) begin
                    resp_nxt  = RSP_ACK;
                    state_nxt = ST_RESP;
                    if (tx_ready) begin
                        start_nxt = 1'b1;
                        txd_nxt   = RSP_ACK;
                    end
                end else begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                err_nxt   = rx_rcv;
                resp_nxt  = reg_rdata;
                state_nxt = ST_RESP;
                if (tx_ready) begin
                    start_nxt = 1'b1;
                    txd_nxt   = reg_rdata;
                end
            end
            ST_RESP: begin
                err_nxt = rx_rcv;
                if (tx_start) begin
                    state_nxt = ST_IDLE;
                end else if (tx_ready) begin
                    start_nxt = 1'b1;
                    txd_nxt   = resp_q;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cmd_wr    <= 1'b0;
            resp_q    <= 8'h00;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            proto_err <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state     <= state_nxt;
            cmd_wr    <= cmd_wr_nxt;
            resp_q    <= resp_nxt;
            reg_addr  <= addr_nxt;
            reg_wdata <= wdata_nxt;
            reg_wr_en <= wr_nxt;
            reg_rd_en <= rd_nxt;
            tx_start  <= start_nxt;
            tx_data   <= txd_nxt;
            proto_err <= err_nxt;
`ifdef CMD_CHECKSUM_EN
            csum_q    <= csum_nxt;
`endif
        end
    end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
Byte-level command responder between the UART receiver (byte strobe in) and the UART transmitter (start/ready handshake out). It decodes host packets arriving from the ESP32, which acts as initiator, into single-cycle register read/write strobes on an internal 8-bit register bus. It sends exactly one response byte per accepted packet. It is the FPGA-side responder end of the serial command link.

Parameters:
- TIMEOUT, 16000, inter-byte timeout in clk cycles (1 ms at 16 MHz); counter width $clog2(TIMEOUT+1)
- ADDR_W, 8, register address width (≤8; upper address byte bits ignored)

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous reset, active-low
- rx_rcv  in  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter idle, can accept a byte
- tx_start  out  1  one-cycle request to transmit tx_data
- tx_data  out  8  response byte; stable from the tx_start cycle until the next response
- reg_addr  out  ADDR_W  register address; held from EXEC until the next packet
- reg_wdata  out  8  write data; held like reg_addr
- reg_wr_en  out  1  one-cycle write strobe
- reg_rd_en  out  1  one-cycle read strobe
- reg_rdata  in  8  read data; valid the cycle after reg_rd_en
- proto_err  out  1  one-cycle pulse on timeout, unknown command or overrun

Behaviour:
- Reset (rstn=0 at posedge clk): state=IDLE; tx_start=0, tx_data=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, proto_err=0; timer cleared. Reset mid-packet discards the packet and sends no response.
- Packets:
  - Write: 0x57 'W', ADDR, DATA → reg write, response ACK 0x06.
  - Read: 0x52 'R', ADDR → reg read, response is the read data byte.
  - Any other first byte → response NAK 0x15, proto_err pulse, return to IDLE.
- FSM states: IDLE, GET_ADDR, GET_DATA, [GET_CSUM], EXEC, RD_WAIT, RESP.
  - IDLE: on rx_rcv, latch cmd. W or R → GET_ADDR. Otherwise load NAK → RESP.
  - GET_ADDR: on rx_rcv, latch reg_addr. W → GET_DATA; R → EXEC.
  - GET_DATA: on rx_rcv, latch reg_wdata → EXEC.
  - EXEC (1 cycle): W asserts reg_wr_en, loads ACK → RESP. R asserts reg_rd_en → RD_WAIT.
  - RD_WAIT (1 cycle): capture reg_rdata into response register → RESP.
  - RESP: wait for tx_ready=1. Then tx_start=1 for exactly one cycle with tx_data=response → IDLE. If tx_ready is already 1, this happens in the first RESP cycle.
- Latency: from the last packet byte's rx_rcv to reg strobe = 1 cycle. To tx_start (tx_ready high) = 2 cycles for write, 3 for read.
- Timeout: timer clears on every rx_rcv and counts while in GET_ADDR/GET_DATA/GET_CSUM. On reaching TIMEOUT: pulse proto_err, go to IDLE, no response, no register strobe. The timer saturates and does not wrap.
- Overrun: rx_rcv during EXEC/RD_WAIT/RESP drops the byte and pulses proto_err. The FSM is otherwise unaffected and the pending response is still sent.
- Simultaneous events: rx_rcv in the same cycle as the timeout match → the byte wins, timer clears, no error. reg_wr_en and reg_rd_en are never high together.
- proto_err is registered, 1 cycle, and never asserted in the same cycle as tx_start for the NAK path (it fires on the decode cycle).

Optional Feature:
- Macro CMD_CHECKSUM_EN.
- Defined: each packet carries a trailing CSUM byte equal to the XOR of all preceding packet bytes. GET_CSUM state is inserted before EXEC. On mismatch: no register strobe, response NAK, proto_err pulse.
- Undefined: no GET_CSUM state, no checksum logic; packets are exactly as listed above.

Decomposition:
- Shared package/include: command codes CMD_WR=0x57, CMD_RD=0x52; response codes RSP_ACK=0x06, RSP_NAK=0x15; FSM state encoding localparams.
- One sub-module: cmd_timeout_timer (clear, enable, parameter TIMEOUT; one-cycle expire output, saturating).

Test Plan:
- Write: bytes 0x57,0x10,0xA5 → reg_wr_en for 1 cycle with reg_addr=0x10, reg_wdata=0xA5; tx_start once with tx_data=0x06.
- Read: bytes 0x52,0x22, reg_rdata=0x3C → reg_rd_en 1 cycle with reg_addr=0x22; tx_start once with tx_data=0x3C, 3 cycles after the ADDR rx_rcv.
- Unknown command: byte 0x41 → proto_err pulse, tx_data=0x15, no reg strobes; next 0x52,0x01 is handled normally.
- Timeout: 0x57,0x05, then silence for TIMEOUT cycles → proto_err pulse, no tx_start, no reg_wr_en. A following full write succeeds.
- Backpressure/overrun: hold tx_ready=0 after a write completes, inject byte 0x99 → proto_err pulse, response held. Raising tx_ready → single tx_start with 0x06.
- CMD_CHECKSUM_EN: 0x57,0x10,0xA5,0xE2 → ACK and write. CSUM 0x00 → NAK, no write.
